sync_fifo_conv: RTL and testbench

Single-clock FIFO with power-of-two width conversion, selectable standard or first-word-fall-through (FWFT) read mode, programmable thresholds, occupancy counts and overflow/underflow flags. It is the single-clock-domain member of the FIFO library. Its main use is rate and width adaptation between datapath stages that share one clock.

---
 rtl/sync_fifo_conv.sv | 135 +++++++++++++
 tb/tb_sync_fifo_conv.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_conv.sv
// Single-clock FIFO with power-of-two width conversion between write and read ports.
// Storage is kept in MIN-width lanes so both sides address the same array little-endian.
module sync_fifo_conv #(
  parameter int WR_DATA_WIDTH     = 64,
  parameter int RD_DATA_WIDTH     = 64,
  parameter int WR_DEPTH          = 1024,
  parameter int FWFT              = 0,
  parameter int PROG_FULL_THRESH  = WR_DEPTH - 16,
  parameter int PROG_EMPTY_THRESH = 16
) (
  input  logic                                                     clk,
  input  logic                                                     global_rst_n,
  input  logic                                                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0]                                 din,
  output logic                                                     full,
  output logic                                                     prog_full,
  output logic                                                     overflow,
  output logic [$clog2(WR_DEPTH):0]                                wr_data_count,
  input  logic                                                     rd_en,
  output logic [RD_DATA_WIDTH-1:0]                                 dout,
  output logic                                                     valid,
  output logic                                                     empty,
  output logic                                                     prog_empty,
  output logic                                                     underflow,
  output logic [$clog2(WR_DEPTH*WR_DATA_WIDTH/RD_DATA_WIDTH):0]    rd_data_count
);

  localparam int MIN_W = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int RW    = WR_DATA_WIDTH / MIN_W;
  localparam int RR    = RD_DATA_WIDTH / MIN_W;
  localparam int L     = WR_DEPTH * RW;
  localparam int LW    = $clog2(L);
  localparam int PW    = LW + 1;
  localparam int RWS   = $clog2(RW);
  localparam int RRS   = $clog2(RR);
  localparam int WCW   = $clog2(WR_DEPTH) + 1;
  localparam int RCW   = $clog2(WR_DEPTH * WR_DATA_WIDTH / RD_DATA_WIDTH) + 1;

  localparam logic [PW-1:0] FULL_AT  = PW'(L - RW + 1);
  localparam logic [PW-1:0] EMPTY_LT = PW'(RR);

  // Handshake: a write is taken when wr_en && !full, a read when rd_en && !empty,
  // both judged on the flag values registered at the previous edge; a request
  // against a set flag is dropped and reported by a one-cycle overflow/underflow.

  logic [MIN_W-1:0] mem [L];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, used_nxt;
  logic [LW-1:0] wr_idx, rd_idx;
  logic          wr_acc, rd_acc;
  logic [WCW-1:0] wr_cnt_nxt;
  logic [RCW-1:0] rd_cnt_nxt;
  logic [RD_DATA_WIDTH-1:0] head;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  assign wr_idx = wr_ptr[LW-1:0];
  assign rd_idx = rd_ptr[LW-1:0];

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (wr_acc) wr_ptr_nxt = wr_ptr + PW'(RW);
    if (rd_acc) rd_ptr_nxt = rd_ptr + PW'(RR);
    used_nxt   = wr_ptr_nxt - rd_ptr_nxt;
    wr_cnt_nxt = WCW'(used_nxt >> RWS);
    rd_cnt_nxt = RCW'(used_nxt >> RRS);
  end

  // Memory is intentionally not reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < RW; i++) begin
        mem[wr_idx + LW'(i)] <= din[i*MIN_W +: MIN_W];
      end
    end
  end

  always_comb begin
    head = '0;
    for (int j = 0; j < RR; j++) begin
      head[j*MIN_W +: MIN_W] = mem[rd_idx + LW'(j)];
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      prog_full     <= 1'b0;
      prog_empty    <= 1'b1;
      wr_data_count <= '0;
      rd_data_count <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      full          <= (used_nxt >= FULL_AT);
      empty         <= (used_nxt < EMPTY_LT);
      prog_full     <= (int'(wr_cnt_nxt) >= PROG_FULL_THRESH);
      prog_empty    <= (int'(rd_cnt_nxt) <= PROG_EMPTY_THRESH);
      wr_data_count <= wr_cnt_nxt;
      rd_data_count <= rd_cnt_nxt;
      overflow      <= wr_en & full;
      underflow     <= rd_en & empty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown as soon as the registered empty flag drops.
    assign dout  = empty ? '0 : head;
    assign valid = ~empty;
  end else begin : g_std
    logic [RD_DATA_WIDTH-1:0] dout_q;
    logic                     valid_q;

    always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= head;
      end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_conv.sv
// Bench for sync_fifo_conv: four configurations share one clock and reset; a monitor
// per instance pops an expected queue whenever that instance presents read data.
module tb_sync_fifo_conv;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
  logic [63:0] exp_q_c[$];
  logic [63:0] exp_q_d[$];
  int pops_a = 0;

  // ---------------- instance A: 64/64, depth 16, standard ----------------
  logic        a_wr_en, a_rd_en, a_full, a_pf, a_ovf, a_valid, a_empty, a_pe, a_udf;
  logic [63:0] a_din, a_dout;
  logic [4:0]  a_wcnt, a_rcnt;

  sync_fifo_conv #(.WR_DATA_WIDTH(64), .RD_DATA_WIDTH(64), .WR_DEPTH(16), .FWFT(0),
                   .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)) u_a (
    .clk(clk), .global_rst_n(rst_n), .wr_en(a_wr_en), .din(a_din), .full(a_full),
    .prog_full(a_pf), .overflow(a_ovf), .wr_data_count(a_wcnt), .rd_en(a_rd_en),
    .dout(a_dout), .valid(a_valid), .empty(a_empty), .prog_empty(a_pe),
    .underflow(a_udf), .rd_data_count(a_rcnt));

  // ---------------- instance B: 64 -> 16, depth 4 ----------------
  logic        b_wr_en, b_rd_en, b_full, b_pf, b_ovf, b_valid, b_empty, b_pe, b_udf;
  logic [63:0] b_din;
  logic [15:0] b_dout;
  logic [2:0]  b_wcnt;
  logic [4:0]  b_rcnt;

  sync_fifo_conv #(.WR_DATA_WIDTH(64), .RD_DATA_WIDTH(16), .WR_DEPTH(4), .FWFT(0),
                   .PROG_FULL_THRESH(3), .PROG_EMPTY_THRESH(1)) u_b (
    .clk(clk), .global_rst_n(rst_n), .wr_en(b_wr_en), .din(b_din), .full(b_full),
    .prog_full(b_pf), .overflow(b_ovf), .wr_data_count(b_wcnt), .rd_en(b_rd_en),
    .dout(b_dout), .valid(b_valid), .empty(b_empty), .prog_empty(b_pe),
    .underflow(b_udf), .rd_data_count(b_rcnt));

  // ---------------- instance C: 16 -> 64, depth 16 ----------------
  logic        c_wr_en, c_rd_en, c_full, c_pf, c_ovf, c_valid, c_empty, c_pe, c_udf;
  logic [15:0] c_din;
  logic [63:0] c_dout;
  logic [4:0]  c_wcnt;
  logic [2:0]  c_rcnt;

  sync_fifo_conv #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(64), .WR_DEPTH(16), .FWFT(0),
                   .PROG_FULL_THRESH(14), .PROG_EMPTY_THRESH(0)) u_c (
    .clk(clk), .global_rst_n(rst_n), .wr_en(c_wr_en), .din(c_din), .full(c_full),
    .prog_full(c_pf), .overflow(c_ovf), .wr_data_count(c_wcnt), .rd_en(c_rd_en),
    .dout(c_dout), .valid(c_valid), .empty(c_empty), .prog_empty(c_pe),
    .underflow(c_udf), .rd_data_count(c_rcnt));

  // ---------------- instance D: 32/32, depth 16, FWFT ----------------
  logic        d_wr_en, d_rd_en, d_full, d_pf, d_ovf, d_valid, d_empty, d_pe, d_udf;
  logic [31:0] d_din, d_dout;
  logic [4:0]  d_wcnt, d_rcnt;

  sync_fifo_conv #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(32), .WR_DEPTH(16), .FWFT(1),
                   .PROG_FULL_THRESH(14), .PROG_EMPTY_THRESH(2)) u_d (
    .clk(clk), .global_rst_n(rst_n), .wr_en(d_wr_en), .din(d_din), .full(d_full),
    .prog_full(d_pf), .overflow(d_ovf), .wr_data_count(d_wcnt), .rd_en(d_rd_en),
    .dout(d_dout), .valid(d_valid), .empty(d_empty), .prog_empty(d_pe),
    .underflow(d_udf), .rd_data_count(d_rcnt));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rst_n && a_valid) begin
      if (exp_q_a.size() == 0) check("a_unexpected_valid", 64'd1, 64'd0);
      else begin
        check("a_dout", a_dout, exp_q_a.pop_front());
        pops_a++;
      end
    end
    if (rst_n && b_valid) begin
      if (exp_q_b.size() == 0) check("b_unexpected_valid", 64'd1, 64'd0);
      else check("b_dout", {48'd0, b_dout}, exp_q_b.pop_front());
    end
    if (rst_n && c_valid) begin
      if (exp_q_c.size() == 0) check("c_unexpected_valid", 64'd1, 64'd0);
      else check("c_dout", c_dout, exp_q_c.pop_front());
    end
    if (rst_n && d_rd_en && !d_empty) begin
      if (exp_q_d.size() == 0) check("d_unexpected_pop", 64'd1, 64'd0);
      else check("d_dout", {32'd0, d_dout}, exp_q_d.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  int          used_m;
  logic [63:0] seq;
  logic        wr, rd;
  logic        pf_prev, pe_prev;
  int          pf_toggles, pe_toggles;

  initial begin
    rst_n = 1'b0;
    a_wr_en = 0; a_rd_en = 0; a_din = '0;
    b_wr_en = 0; b_rd_en = 0; b_din = '0;
    c_wr_en = 0; c_rd_en = 0; c_din = '0;
    d_wr_en = 0; d_rd_en = 0; d_din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_full", a_full, 0);
    check("rst_a_empty", a_empty, 1);
    check("rst_a_pf", a_pf, 0);
    check("rst_a_pe", a_pe, 1);
    check("rst_a_wcnt", a_wcnt, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_dout", a_dout, 0);
    check("rst_d_empty", d_empty, 1);
    check("rst_d_dout", d_dout, 0);
    rst_n = 1'b1;
    tick();

    // ---- 1: fill to full, overflow, drain, underflow ----
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1; a_din = 64'(i);
      exp_q_a.push_back(64'(i));
      tick();
    end
    a_wr_en = 0;
    check("t1_full", a_full, 1);
    check("t1_wcnt16", a_wcnt, 16);
    check("t1_pf", a_pf, 1);
    check("t1_not_empty", a_empty, 0);
    a_wr_en = 1; a_din = 64'd99;
    tick();
    a_wr_en = 0;
    check("t1_overflow", a_ovf, 1);
    check("t1_wcnt_hold", a_wcnt, 16);
    tick();
    check("t1_overflow_pulse", a_ovf, 0);
    check("t1_valid_idle", a_valid, 0);
    for (int i = 0; i < 16; i++) begin
      a_rd_en = 1;
      tick();
    end
    a_rd_en = 0;
    check("t1_empty", a_empty, 1);
    check("t1_rcnt0", a_rcnt, 0);
    a_rd_en = 1;
    tick();
    a_rd_en = 0;
    check("t1_underflow", a_udf, 1);
    check("t1_valid_refused", a_valid, 0);
    tick();
    check("t1_underflow_pulse", a_udf, 0);
    check("t1_pops", 64'(pops_a), 16);

    // ---- 2: wide to narrow ----
    b_wr_en = 1; b_din = 64'h0004_0003_0002_0001;
    exp_q_b.push_back(64'h1); exp_q_b.push_back(64'h2);
    exp_q_b.push_back(64'h3); exp_q_b.push_back(64'h4);
    tick();
    b_wr_en = 0;
    check("t2_rcnt4", b_rcnt, 4);
    check("t2_wcnt1", b_wcnt, 1);
    for (int i = 0; i < 4; i++) begin
      b_rd_en = 1;
      tick();
    end
    b_rd_en = 0;
    check("t2_empty", b_empty, 1);

    // ---- 3: narrow to wide ----
    c_wr_en = 1; c_din = 16'h000A; tick();
    check("t3_empty_1", c_empty, 1);
    c_din = 16'h000B; tick();
    check("t3_empty_2", c_empty, 1);
    c_din = 16'h000C; tick();
    check("t3_empty_3", c_empty, 1);
    c_din = 16'h000D;
    exp_q_c.push_back(64'h000D_000C_000B_000A);
    tick();
    c_wr_en = 0;
    check("t3_not_empty", c_empty, 0);
    check("t3_rcnt1", c_rcnt, 1);
    check("t3_wcnt4", c_wcnt, 4);
    c_rd_en = 1; tick(); c_rd_en = 0;
    check("t3_empty_after", c_empty, 1);

    // ---- 4: FWFT ----
    d_wr_en = 1; d_din = 32'hDEADBEEF;
    exp_q_d.push_back(64'hDEADBEEF);
    tick();
    d_wr_en = 0;
    check("t4_dout_fwft", d_dout, 64'hDEADBEEF);
    check("t4_not_empty", d_empty, 0);
    check("t4_valid", d_valid, 1);
    d_rd_en = 1; tick(); d_rd_en = 0;
    check("t4_empty", d_empty, 1);
    check("t4_valid_low", d_valid, 0);

    // ---- 5: free-running traffic with fill and drain phases ----
    used_m = 0; seq = 64'h1000;
    pf_prev = a_pf; pe_prev = a_pe; pf_toggles = 0; pe_toggles = 0;
    for (int c = 0; c < 5000; c++) begin
      wr = !a_full && ((c % 64) < 40);
      rd = !a_empty && ((c % 64) >= 20);
      a_wr_en = wr; a_rd_en = rd; a_din = seq;
      if (wr) begin
        exp_q_a.push_back(seq);
        seq++;
      end
      used_m = used_m + int'(wr) - int'(rd);
      tick();
      check("t5_ovf", a_ovf, 0);
      check("t5_udf", a_udf, 0);
      check("t5_wcnt", a_wcnt, 64'(used_m));
      check("t5_full", a_full, 64'(used_m == 16));
      check("t5_empty", a_empty, 64'(used_m == 0));
      check("t5_pf", a_pf, 64'(used_m >= 12));
      check("t5_pe", a_pe, 64'(used_m <= 3));
      if (a_pf != pf_prev) pf_toggles++;
      if (a_pe != pe_prev) pe_toggles++;
      pf_prev = a_pf; pe_prev = a_pe;
    end
    a_wr_en = 0;
    for (int i = 0; i < 20; i++) begin
      a_rd_en = !a_empty;
      tick();
    end
    a_rd_en = 0;
    tick();
    check("t5_drained", a_empty, 1);
    check("t5_pf_toggles", 64'(pf_toggles >= 20), 1);
    check("t5_pe_toggles", 64'(pe_toggles >= 20), 1);
    check("t5_queue_empty", 64'(exp_q_a.size()), 0);

    // ---- 6: asynchronous reset mid-operation ----
    for (int i = 0; i < 10; i++) begin
      a_wr_en = 1; a_din = 64'(100 + i);
      tick();
    end
    a_wr_en = 0;
    check("t6_wcnt10", a_wcnt, 10);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_empty", a_empty, 1);
    check("t6_rst_full", a_full, 0);
    check("t6_rst_wcnt", a_wcnt, 0);
    check("t6_rst_rcnt", a_rcnt, 0);
    check("t6_rst_pe", a_pe, 1);
    check("t6_rst_pf", a_pf, 0);
    check("t6_rst_valid", a_valid, 0);
    check("t6_rst_dout", a_dout, 0);
    exp_q_a.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    a_wr_en = 1; a_din = 64'h55;
    exp_q_a.push_back(64'h55);
    tick();
    a_wr_en = 0;
    a_rd_en = 1; tick(); a_rd_en = 0;
    check("t6_empty_after", a_empty, 1);
    tick();

    check("end_q_a", 64'(exp_q_a.size()), 0);
    check("end_q_b", 64'(exp_q_b.size()), 0);
    check("end_q_c", 64'(exp_q_c.size()), 0);
    check("end_q_d", 64'(exp_q_d.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
